// File: rtl/raster_fill_sched.sv
// rtl/raster_fill_sched.sv - round-robin clear/rectangle fill scheduler emitting raster-order pixel writes
module raster_fill_sched #(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int COLOR_BITS = 12,
    localparam int X_BITS     = $clog2(WIDTH),
    localparam int Y_BITS     = $clog2(HEIGHT),
    localparam int TOTAL_BITS = $clog2(WIDTH * HEIGHT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_req,
    input  logic [COLOR_BITS-1:0] clr_color,
    output logic                  clr_ack,
    input  logic                  rect_req,
    input  logic [X_BITS-1:0]     rect_x0,
    input  logic [Y_BITS-1:0]     rect_y0,
    input  logic [X_BITS:0]       rect_w,
    input  logic [Y_BITS:0]       rect_h,
    input  logic [COLOR_BITS-1:0] rect_color,
    output logic                  rect_ack,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic [X_BITS-1:0]     pix_x,
    output logic [Y_BITS-1:0]     pix_y,
    output logic [TOTAL_BITS-1:0] pix_addr,
    output logic [COLOR_BITS-1:0] pix_color,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [X_BITS+1:0]     W_EXT  = (X_BITS+2)'(WIDTH);
    localparam logic [Y_BITS+1:0]     H_EXT  = (Y_BITS+2)'(HEIGHT);
    localparam logic [TOTAL_BITS-1:0] W_STEP = TOTAL_BITS'(WIDTH);
    localparam logic [X_BITS-1:0]     X_MAX  = X_BITS'(WIDTH - 1);
    localparam logic [Y_BITS-1:0]     Y_MAX  = Y_BITS'(HEIGHT - 1);

    state_t                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  clr_ack_q, clr_ack_d;
    logic                  rect_ack_q, rect_ack_d;
    logic                  done_q, done_d;
    logic                  pix_valid_q, pix_valid_d;
    logic [X_BITS-1:0]     pix_x_q, pix_x_d;
    logic [Y_BITS-1:0]     pix_y_q, pix_y_d;
    logic [TOTAL_BITS-1:0] pix_addr_q, pix_addr_d;
    logic [COLOR_BITS-1:0] pix_color_q, pix_color_d;
    logic [TOTAL_BITS-1:0] row_base_q, row_base_d;
    logic [X_BITS-1:0]     x0_q, x0_d;
    logic [X_BITS-1:0]     x_end_q, x_end_d;
    logic [Y_BITS-1:0]     y_end_q, y_end_d;

    logic [X_BITS+1:0]     x_sum, x_lim;
    logic [Y_BITS+1:0]     y_sum, y_lim;
    logic [X_BITS-1:0]     rect_x_end;
    logic [Y_BITS-1:0]     rect_y_end;
    logic                  rect_empty;
    logic                  grant_ok;
    logic                  pick_clr;

    // Clip in a widened domain so x0+w never wraps before the min().
    always_comb begin
        x_sum      = {2'b00, rect_x0} + {1'b0, rect_w};
        y_sum      = {2'b00, rect_y0} + {1'b0, rect_h};
        x_lim      = (x_sum > W_EXT) ? W_EXT : x_sum;
        y_lim      = (y_sum > H_EXT) ? H_EXT : y_sum;
        rect_x_end = X_BITS'(x_lim - (X_BITS+2)'(1));
        rect_y_end = Y_BITS'(y_lim - (Y_BITS+2)'(1));
        rect_empty = (rect_w == '0) || (rect_h == '0) ||
                     ({2'b00, rect_x0} >= W_EXT) || ({2'b00, rect_y0} >= H_EXT);
    end

    // No grant while an ack is out, so a level request is not granted twice.
    assign grant_ok = (state_q == IDLE) && !clr_ack_q && !rect_ack_q;
    assign pick_clr = clr_req && (!rect_req || last_grant_q);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        clr_ack_d    = 1'b0;
        rect_ack_d   = 1'b0;
        done_d       = 1'b0;
        pix_valid_d  = pix_valid_q;
        pix_x_d      = pix_x_q;
        pix_y_d      = pix_y_q;
        pix_addr_d   = pix_addr_q;
        pix_color_d  = pix_color_q;
        row_base_d   = row_base_q;
        x0_d         = x0_q;
        x_end_d      = x_end_q;
        y_end_d      = y_end_q;

        case (state_q)
            IDLE: begin
                // An ack seen while still IDLE means the granted job was empty.
                done_d = clr_ack_q | rect_ack_q;
                if (grant_ok && (clr_req || rect_req)) begin
                    if (pick_clr) begin
                        clr_ack_d    = 1'b1;
                        last_grant_d = 1'b0;
                        pix_color_d  = clr_color;
                        x0_d         = '0;
                        x_end_d      = X_MAX;
                        y_end_d      = Y_MAX;
                        pix_x_d      = '0;
                        pix_y_d      = '0;
                        pix_addr_d   = '0;
                        row_base_d   = '0;
                        pix_valid_d  = 1'b1;
                        state_d      = RUN;
                    end else begin
                        rect_ack_d   = 1'b1;
                        last_grant_d = 1'b1;
                        if (!rect_empty) begin
                            pix_color_d = rect_color;
                            x0_d        = rect_x0;
                            x_end_d     = rect_x_end;
                            y_end_d     = rect_y_end;
                            pix_x_d     = rect_x0;
                            pix_y_d     = rect_y0;
                            pix_addr_d  = TOTAL_BITS'(rect_y0) * W_STEP + TOTAL_BITS'(rect_x0);
                            row_base_d  = TOTAL_BITS'(rect_y0) * W_STEP + TOTAL_BITS'(rect_x0);
                            pix_valid_d = 1'b1;
                            state_d     = RUN;
                        end
                    end
                end
            end
            RUN: begin
                if (pix_ready) begin
                    if (pix_x_q == x_end_q) begin
                        if (pix_y_q == y_end_q) begin
                            pix_valid_d = 1'b0;
                            done_d      = 1'b1;
                            state_d     = IDLE;
                        end else begin
                            pix_x_d    = x0_q;
                            pix_y_d    = pix_y_q + 1'b1;
                            row_base_d = row_base_q + W_STEP;
                            pix_addr_d = row_base_q + W_STEP;
                        end
                    end else begin
                        pix_x_d    = pix_x_q + 1'b1;
                        pix_addr_d = pix_addr_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            clr_ack_q    <= 1'b0;
            rect_ack_q   <= 1'b0;
            done_q       <= 1'b0;
            pix_valid_q  <= 1'b0;
            pix_x_q      <= '0;
            pix_y_q      <= '0;
            pix_addr_q   <= '0;
            pix_color_q  <= '0;
            row_base_q   <= '0;
            x0_q         <= '0;
            x_end_q      <= '0;
            y_end_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            clr_ack_q    <= clr_ack_d;
            rect_ack_q   <= rect_ack_d;
            done_q       <= done_d;
            pix_valid_q  <= pix_valid_d;
            pix_x_q      <= pix_x_d;
            pix_y_q      <= pix_y_d;
            pix_addr_q   <= pix_addr_d;
            pix_color_q  <= pix_color_d;
            row_base_q   <= row_base_d;
            x0_q         <= x0_d;
            x_end_q      <= x_end_d;
            y_end_q      <= y_end_d;
        end
    end

    assign clr_ack   = clr_ack_q;
    assign rect_ack  = rect_ack_q;
    assign done      = done_q;
    assign pix_valid = pix_valid_q;
    assign pix_x     = pix_x_q;
    assign pix_y     = pix_y_q;
    assign pix_addr  = pix_addr_q;
    assign pix_color = pix_color_q;
    assign busy      = (state_q == RUN);

endmodule
